// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered RV32I conditional-branch resolution stage
//
// Accepts one branch per cycle over in_valid/in_ready. It evaluates the branch
// condition and computes the target and next PC. The result is returned one
// cycle later from a single-entry output register (out_valid/out_ready).
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   in_*             operands, funct3, PC, B-immediate, front-end prediction
//   out_*            taken, target, next PC, mispredict/misaligned/illegal flags
//   cnt_clear, cnt_* performance counter clear and counters (optional)
//
// Optional feature: define BRANCH_PERF_CNT_EN to build the three saturating
// performance counters and the cnt_clear input. Without it, these ports do not exist.

module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
`ifdef BRANCH_PERF_CNT_EN
    input  logic            cnt_clear,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_mispredict,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_mispredict,
    output logic            out_misaligned,
    output logic            out_illegal
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    state_t            state_q, state_d;
    logic              taken_q, taken_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [XLEN-1:0]   next_pc_q, next_pc_d;
    logic              mispredict_q, mispredict_d;
    logic              misaligned_q, misaligned_d;
    logic              illegal_q, illegal_d;

    logic              accept;
    logic              cmp_eq;
    logic              cmp_lt_u;
    logic              cmp_lt_s;
    logic              res_taken;
    logic              res_illegal;
    logic [XLEN-1:0]   res_target;
    logic [XLEN-1:0]   res_seq_pc;
    logic [XLEN-1:0]   res_next_pc;
    logic              res_mispredict;
    logic              res_misaligned;

    // in_ready is forced high during reset. The reset edge empties the
    // register anyway, and no accept can happen on a reset cycle.
    assign in_ready = rst || (state_q == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    // ---------------------------------------------------------------
    // Condition evaluation and address arithmetic (all modulo 2^XLEN)
    // ---------------------------------------------------------------
    assign cmp_eq   = (in_rs1 == in_rs2);
    assign cmp_lt_u = (in_rs1 < in_rs2);
    assign cmp_lt_s = ($signed(in_rs1) < $signed(in_rs2));

    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        unique case (in_funct3)
            F3_BEQ:  res_taken = cmp_eq;
            F3_BNE:  res_taken = !cmp_eq;
            F3_BLT:  res_taken = cmp_lt_s;
            F3_BGE:  res_taken = !cmp_lt_s;
            F3_BLTU: res_taken = cmp_lt_u;
            F3_BGEU: res_taken = !cmp_lt_u;
            default: res_illegal = 1'b1;   // 010 / 011 are not branches
        endcase
    end

    assign res_target     = in_pc + in_imm;
    assign res_seq_pc     = in_pc + XLEN'(4);
    assign res_next_pc    = res_taken ? res_target : res_seq_pc;
    // An illegal op never reports a misprediction. The decode trap takes over.
    assign res_mispredict = !res_illegal && (res_taken != in_pred_taken);
    assign res_misaligned = res_taken && (res_target[1:0] != 2'b00);

    // ---------------------------------------------------------------
    // Output register: EMPTY/FULL with load-on-accept, drain-on-ready
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        taken_d      = taken_q;
        target_d     = target_q;
        next_pc_d    = next_pc_q;
        mispredict_d = mispredict_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;

        if (accept) begin
            // Covers both the fill from EMPTY and the drain-and-refill in FULL.
            state_d      = ST_FULL;
            taken_d      = res_taken;
            target_d     = res_target;
            next_pc_d    = res_next_pc;
            mispredict_d = res_mispredict;
            misaligned_d = res_misaligned;
            illegal_d    = res_illegal;
        end else if ((state_q == ST_FULL) && out_ready) begin
            // Payload is left as-is. out_valid alone tells the consumer it is stale.
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            taken_q      <= 1'b0;
            target_q     <= '0;
            next_pc_q    <= '0;
            mispredict_q <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            next_pc_q    <= next_pc_d;
            mispredict_q <= mispredict_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid      = (state_q == ST_FULL);
    assign out_taken      = taken_q;
    assign out_target     = target_q;
    assign out_next_pc    = next_pc_q;
    assign out_mispredict = mispredict_q;
    assign out_misaligned = misaligned_q;
    assign out_illegal    = illegal_q;

`ifdef BRANCH_PERF_CNT_EN
    // ---------------------------------------------------------------
    // Saturating performance counters. They update at accept time, not
    // at drain time, and illegal encodings are not counted.
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] cnt_branches_q,   cnt_branches_d;
    logic [CNT_W-1:0] cnt_taken_q,      cnt_taken_d;
    logic [CNT_W-1:0] cnt_mispredict_q, cnt_mispredict_d;
    logic             cnt_event;

    assign cnt_event = accept && !res_illegal;

    always_comb begin
        cnt_branches_d   = cnt_branches_q;
        cnt_taken_d      = cnt_taken_q;
        cnt_mispredict_d = cnt_mispredict_q;

        if (cnt_clear) begin
            cnt_branches_d   = '0;
            cnt_taken_d      = '0;
            cnt_mispredict_d = '0;
        end else if (cnt_event) begin
            if (cnt_branches_q != '1) begin
                cnt_branches_d = cnt_branches_q + CNT_W'(1);
            end
            if (res_taken && (cnt_taken_q != '1)) begin
                cnt_taken_d = cnt_taken_q + CNT_W'(1);
            end
            if (res_mispredict && (cnt_mispredict_q != '1)) begin
                cnt_mispredict_d = cnt_mispredict_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches_q   <= '0;
            cnt_taken_q      <= '0;
            cnt_mispredict_q <= '0;
        end else begin
            cnt_branches_q   <= cnt_branches_d;
            cnt_taken_q      <= cnt_taken_d;
            cnt_mispredict_q <= cnt_mispredict_d;
        end
    end

    assign cnt_branches   = cnt_branches_q;
    assign cnt_taken      = cnt_taken_q;
    assign cnt_mispredict = cnt_mispredict_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered branch resolution stage for the RV32I datapath. It accepts one conditional-branch operation per cycle over a valid/ready handshake and evaluates all six RV32I branch conditions (BEQ, BNE, BLT, BGE, BLTU, BGEU). It returns the taken decision, branch target, next PC, and misprediction, misalignment and illegal-encoding flags one cycle later through a single-entry output register. Optional saturating performance counters track branch behaviour. It sits between register-file read and PC-select logic, and is the pipelined successor of the combinational comparator.

## Interface
Parameters:
- XLEN, 32, operand/PC/immediate width (≥ 8)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input operation present
- in_ready  out  1  block can accept input this cycle
- in_rs1  in  XLEN  first source operand
- in_rs2  in  XLEN  second source operand
- in_funct3  in  3  branch condition code
- in_pc  in  XLEN  PC of the branch
- in_imm  in  XLEN  sign-extended B-immediate
- in_pred_taken  in  1  front-end prediction
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts the result
- out_taken  out  1  condition true
- out_target  out  XLEN  in_pc + in_imm, modulo 2^XLEN
- out_next_pc  out  XLEN  out_target if taken, else in_pc + 4 (mod 2^XLEN)
- out_mispredict  out  1  out_taken != in_pred_taken; 0 if illegal
- out_misaligned  out  1  taken and out_target[1:0] != 0
- out_illegal  out  1  funct3 ∈ {010, 011}
- cnt_clear  in  1  synchronous clear of all counters
- cnt_branches / cnt_taken / cnt_mispredict  out  CNT_W each  counters (present only with the macro)

## Operation
- Conditions:
  - 000 BEQ: rs1 == rs2
  - 001 BNE: rs1 != rs2
  - 100 BLT: signed <
  - 101 BGE: signed ≥
  - 110 BLTU: unsigned <
  - 111 BGEU: unsigned ≥
  - 010/011: taken = 0, illegal = 1, mispredict = 0, misaligned = 0
- Output register states:
  - EMPTY (out_valid = 0) or FULL (out_valid = 1)
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready)
- Accept condition: in_valid && in_ready.
  - On accept, the register loads the new result and becomes or stays FULL.
- Drain without refill: out_valid && out_ready && !accept → EMPTY.
- FULL && !out_ready: all out_* held stable; input stalled.
- All arithmetic wraps at XLEN bits; no carry-out flags.
- in_* are sampled only on accept; values on non-accepted cycles are ignored.

## Timing
- Latency: 1 cycle, accept at edge N → out_valid high after edge N.
- Throughput: 1 per cycle while out_ready = 1.
- Reset values: out_valid = 0, out_taken = 0, out_target = 0, out_next_pc = 0, all flags 0, counters 0.
- in_ready is 1 while held in reset.
- rst mid-operation discards the held result. No accept occurs on a reset cycle.
- Simultaneous drain and accept in a FULL cycle: the new result replaces the old one; no bubble.

## Configuration
- BRANCH_PERF_CNT_EN defined: the three counters exist.
  - All three are updated on each accepted non-illegal op: branches +1, taken +1 if taken, mispredict +1 if mispredict.
  - Each counter saturates at 2^CNT_W − 1.
  - cnt_clear takes priority over increment. rst also clears the counters.
- Not defined: counter ports and logic are absent. cnt_clear is not a port.

## Test plan
- BLT/BLTU sign boundary: rs1 = 0xFFFF_FFFF, rs2 = 1, funct3 100 → taken = 1; same operands with funct3 110 → taken = 0.
- Target wrap: pc = 0xFFFF_FFF8, imm = 0x10, BEQ, rs1 = rs2 = 5 → target = next_pc = 0x0000_0008.
  - Same case with BNE → next_pc = 0xFFFF_FFFC.
- Backpressure: three back-to-back valid ops with out_ready = 0 for 3 cycles.
  - First result held stable, in_ready = 0.
  - Release → results appear in order, one per cycle, none lost or duplicated.
- Illegal and misalignment: funct3 = 010, pred_taken = 1 → illegal = 1, taken = 0, mispredict = 0.
  - BEQ taken with imm = 0x6 → misaligned = 1.
- Reset mid-stall: FULL with out_ready = 0, assert rst for 1 cycle → out_valid = 0, in_ready = 1, outputs zeroed next cycle.
- Counters (macro on, CNT_W = 2): 5 taken, mispredicted ops → all counters saturate at 3.
  - cnt_clear together with an accept → all counters 0.
